// File: rtl/hazard_ctrl_if.sv
// Decode-side request signals and pipeline-control responses for hazard_ctrl.
// master = pipeline/decode driver, slave = hazard_ctrl.
interface hazard_ctrl_if;
   logic       dec_valid_i;
   logic [2:0] dec_rs_sel_i;
   logic       dec_rs_used_i;
   logic [2:0] dec_rt_sel_i;
   logic       dec_rt_used_i;
   logic       dec_wr_en_i;
   logic [2:0] dec_wr_sel_i;
   logic       dec_is_load_i;
   logic       dec_redirect_i;
   logic       dec_halt_i;
   logic       mem_stall_i;

   logic       pc_en_o;
   logic       ftch_dec_en_o;
   logic       dec_exe_en_o;
   logic       exe_mem_en_o;
   logic       mem_wb_en_o;
   logic       ftch_dec_flush_o;
   logic       dec_exe_bubble_o;
   logic       halted_o;
   logic       err_o;

   modport master (
      output dec_valid_i, dec_rs_sel_i, dec_rs_used_i, dec_rt_sel_i, dec_rt_used_i,
             dec_wr_en_i, dec_wr_sel_i, dec_is_load_i, dec_redirect_i, dec_halt_i,
             mem_stall_i,
      input  pc_en_o, ftch_dec_en_o, dec_exe_en_o, exe_mem_en_o, mem_wb_en_o,
             ftch_dec_flush_o, dec_exe_bubble_o, halted_o, err_o
   );

   modport slave (
      input  dec_valid_i, dec_rs_sel_i, dec_rs_used_i, dec_rt_sel_i, dec_rt_used_i,
             dec_wr_en_i, dec_wr_sel_i, dec_is_load_i, dec_redirect_i, dec_halt_i,
             mem_stall_i,
      output pc_en_o, ftch_dec_en_o, dec_exe_en_o, exe_mem_en_o, mem_wb_en_o,
             ftch_dec_flush_o, dec_exe_bubble_o, halted_o, err_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: RAW scoreboard stalls, redirect flush, halt drain.
// Define HAZ_FORWARDING_EN to stall only on load-use (EX load) instead of any in-flight writer.
module hazard_ctrl (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_e;

   typedef struct packed {
      logic       valid;
      logic [2:0] wr_sel;
      logic       is_load;
   } sb_entry_t;

   localparam int unsigned SB_DEPTH = 3;

   state_e     state_q, state_d;
   sb_entry_t  sb_q [SB_DEPTH];
   sb_entry_t  sb_d [SB_DEPTH];
   logic [1:0] cnt_q, cnt_d;

   logic rs_hit, rt_hit, raw_hit, data_stall;

   always_comb begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
`ifdef HAZ_FORWARDING_EN
      rs_hit = sb_q[0].valid && sb_q[0].is_load && (sb_q[0].wr_sel == hz.dec_rs_sel_i);
      rt_hit = sb_q[0].valid && sb_q[0].is_load && (sb_q[0].wr_sel == hz.dec_rt_sel_i);
`else
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
         if (sb_q[i].valid && (sb_q[i].wr_sel == hz.dec_rs_sel_i)) rs_hit = 1'b1;
         if (sb_q[i].valid && (sb_q[i].wr_sel == hz.dec_rt_sel_i)) rt_hit = 1'b1;
      end
`endif
      raw_hit    = hz.dec_valid_i & ((hz.dec_rs_used_i & rs_hit) | (hz.dec_rt_used_i & rt_hit));
      data_stall = (state_q == RUN) & raw_hit & ~hz.mem_stall_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int unsigned i = 0; i < SB_DEPTH; i++) sb_q[i] <= sb_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int unsigned i = 0; i < SB_DEPTH; i++) sb_d[i] = sb_q[i];
      // Memory stall freezes the whole pipeline, so scoreboard and drain count hold with it.
      if (!hz.mem_stall_i) begin
         sb_d[2] = sb_q[1];
         sb_d[1] = sb_q[0];
         sb_d[0] = '{valid:   hz.dec_valid_i & hz.dec_wr_en_i & ~data_stall,
                     wr_sel:  hz.dec_wr_sel_i,
                     is_load: hz.dec_is_load_i};
         case (state_q)
            RUN: begin
               if (hz.dec_valid_i && hz.dec_halt_i && !raw_hit) begin
                  state_d = DRAIN;
                  cnt_d   = 2'd3;
               end
            end
            DRAIN: begin
               cnt_d = cnt_q - 2'd1;
               if (cnt_q == 2'd1) state_d = HALT;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      hz.pc_en_o          = 1'b1;
      hz.ftch_dec_en_o    = 1'b1;
      hz.dec_exe_en_o     = 1'b1;
      hz.exe_mem_en_o     = 1'b1;
      hz.mem_wb_en_o      = 1'b1;
      hz.ftch_dec_flush_o = 1'b0;
      hz.dec_exe_bubble_o = data_stall;
      hz.halted_o         = (state_q == HALT);
      hz.err_o            = hz.dec_valid_i & ((hz.dec_halt_i & hz.dec_redirect_i) | (state_q == HALT));

      if (hz.mem_stall_i || state_q == HALT) begin
         hz.pc_en_o       = 1'b0;
         hz.ftch_dec_en_o = 1'b0;
         hz.dec_exe_en_o  = 1'b0;
         hz.exe_mem_en_o  = 1'b0;
         hz.mem_wb_en_o   = 1'b0;
      end else if (state_q == DRAIN) begin
         hz.pc_en_o          = 1'b0;
         hz.ftch_dec_en_o    = 1'b0;
         hz.ftch_dec_flush_o = 1'b1;
      end else if (raw_hit) begin
         // A redirect held in decode is simply re-presented once the stall clears.
         hz.pc_en_o       = 1'b0;
         hz.ftch_dec_en_o = 1'b0;
      end else if (hz.dec_valid_i && (hz.dec_redirect_i || hz.dec_halt_i)) begin
         hz.ftch_dec_flush_o = 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl; each table row is one clock cycle.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if hif ();
   hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hif));

`ifdef HAZ_FORWARDING_EN
   localparam int LU_STALLS  = 1;
   localparam int RAW_STALLS = 0;
`else
   localparam int LU_STALLS  = 3;
   localparam int RAW_STALLS = 3;
`endif

   // {pc, fd, de, em, mw, flush, bubble, halted, err}
   localparam logic [8:0] E_RUN = 9'b111110000;
   localparam logic [8:0] E_STL = 9'b001110100;
   localparam logic [8:0] E_MS  = 9'b000000000;
   localparam logic [8:0] E_FL  = 9'b111111000;
   localparam logic [8:0] E_FLE = 9'b111111001;
   localparam logic [8:0] E_DRN = 9'b001111000;
   localparam logic [8:0] E_HLT = 9'b000000010;
   localparam logic [8:0] E_HER = 9'b000000011;

   typedef struct {
      string      name;
      logic       r;
      logic       v;
      logic [2:0] rs;
      logic       rsu;
      logic [2:0] rt;
      logic       rtu;
      logic       wen;
      logic [2:0] wsel;
      logic       ld;
      logic       rd;
      logic       hl;
      logic       ms;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic push(input string nm, input logic r, input logic v,
                       input logic [2:0] rs, input logic rsu, input logic [2:0] rt, input logic rtu,
                       input logic wen, input logic [2:0] wsel, input logic ld,
                       input logic rd, input logic hl, input logic ms, input logic [8:0] e);
      vec_t x;
      x.name = nm; x.r = r; x.v = v; x.rs = rs; x.rsu = rsu; x.rt = rt; x.rtu = rtu;
      x.wen = wen; x.wsel = wsel; x.ld = ld; x.rd = rd; x.hl = hl; x.ms = ms; x.exp = e;
      tbl.push_back(x);
   endtask

   task automatic idle(input int n, input string nm);
      for (int k = 0; k < n; k++) push(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
   endtask

   task automatic drive(input vec_t x);
      rst                = x.r;
      hif.dec_valid_i    = x.v;
      hif.dec_rs_sel_i   = x.rs;
      hif.dec_rs_used_i  = x.rsu;
      hif.dec_rt_sel_i   = x.rt;
      hif.dec_rt_used_i  = x.rtu;
      hif.dec_wr_en_i    = x.wen;
      hif.dec_wr_sel_i   = x.wsel;
      hif.dec_is_load_i  = x.ld;
      hif.dec_redirect_i = x.rd;
      hif.dec_halt_i     = x.hl;
      hif.mem_stall_i    = x.ms;
   endtask

   task automatic check(input string nm, input logic [8:0] e);
      logic [8:0] got;
      got = {hif.pc_en_o, hif.ftch_dec_en_o, hif.dec_exe_en_o, hif.exe_mem_en_o,
             hif.mem_wb_en_o, hif.ftch_dec_flush_o, hif.dec_exe_bubble_o,
             hif.halted_o, hif.err_o};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s: got %b expected %b (pc fd de em mw flush bubble halted err)", nm, got, e);
      end
   endtask

   vec_t cur;

   initial begin
      cur = '{name: "init", r: 1, v: 0, rs: 0, rsu: 0, rt: 0, rtu: 0, wen: 0, wsel: 0,
              ld: 0, rd: 0, hl: 0, ms: 0, exp: E_RUN};
      drive(cur);

      push("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
      idle(1, "idle");
      // load r3, then add r1,r3,r2
      push("ld_r3", 0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, E_RUN);
      for (int k = 0; k < LU_STALLS; k++) push("lu_stall", 0, 1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 0, E_STL);
      push("lu_go", 0, 1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 0, E_RUN);
      idle(3, "idle");
      // add r3, then add r4,r3,r3
      push("add_r3", 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, E_RUN);
      for (int k = 0; k < RAW_STALLS; k++) push("raw_stall", 0, 1, 3, 1, 3, 1, 1, 4, 0, 0, 0, 0, E_STL);
      push("raw_go", 0, 1, 3, 1, 3, 1, 1, 4, 0, 0, 0, 0, E_RUN);
      idle(3, "idle");
      // rt-only dependency on a load
      push("ld_r6", 0, 1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, E_RUN);
      for (int k = 0; k < LU_STALLS; k++) push("rt_stall", 0, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, E_STL);
      push("rt_go", 0, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, E_RUN);
      idle(3, "idle");
      // matching selects but invalid decode / unused sources
      push("ld_r2", 0, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, E_RUN);
      push("invalid_dec", 0, 0, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0, E_RUN);
      push("unused_src", 0, 1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, E_RUN);
      idle(3, "idle");
      // mem_stall for two cycles while the load-use consumer waits
      push("ld_r3b", 0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, E_RUN);
      push("ms_1", 0, 1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 1, E_MS);
      push("ms_2", 0, 1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 1, E_MS);
      for (int k = 0; k < LU_STALLS; k++) push("ms_bubble", 0, 1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 0, E_STL);
      push("ms_go", 0, 1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 0, E_RUN);
      idle(3, "idle");
      // branch on r5 while r5 is still in flight
      push("add_r5", 0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, E_RUN);
      for (int k = 0; k < RAW_STALLS; k++) push("br_wait", 0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, E_STL);
      push("br_taken", 0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, E_FL);
      push("after_br", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
      push("redir_invalid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_RUN);
      idle(3, "idle");
      // halt, drain with one mem_stall cycle, then HALT
      push("halt", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FL);
      push("drain3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DRN);
      push("drain_ms", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_MS);
      push("drain2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DRN);
      push("drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DRN);
      push("halted", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HLT);
      push("halt_ms", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HLT);
      push("halt_valid_err", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HER);
      push("halt_stays", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HLT);
      push("rst_in_halt", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
      push("after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         drive(tbl[i]);
         @(negedge clk);
         check(tbl[i].name, tbl[i].exp);
      end

      // Halt+redirect, then asynchronous reset in the middle of DRAIN
      @(posedge clk); #1;
      cur.r = 0; cur.v = 1; cur.hl = 1; cur.rd = 1;
      drive(cur);
      @(negedge clk); check("halt_redirect_err", E_FLE);
      @(posedge clk); #1;
      cur.v = 0; cur.hl = 0; cur.rd = 0;
      drive(cur);
      @(negedge clk); check("drain_before_rst", E_DRN);
      #2 rst = 1'b1;
      #1 check("rst_mid_drain", E_RUN);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); check("post_rst_run", E_RUN);

      // Asynchronous reset while a load-use stall is in progress
      @(posedge clk); #1;
      cur.v = 1; cur.wen = 1; cur.wsel = 3; cur.ld = 1;
      drive(cur);
      @(negedge clk); check("ld_before_rst", E_RUN);
      @(posedge clk); #1;
      cur.rs = 3; cur.rsu = 1; cur.wsel = 1; cur.ld = 0;
      drive(cur);
      @(negedge clk); check("stall_before_rst", E_STL);
      #2 rst = 1'b1;
      #1 check("rst_mid_stall", E_RUN);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); check("post_rst_consumer", E_RUN);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
